// File: rtl/requantize_exp_arbiter.sv
// Round-robin arbiter that shares the single-port requantize exponent ROM between NUM_REQ lanes.
// Issues one ROM read per cycle and routes the 1-cycle-latency result back to the issuing lane.
module requantize_exp_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_BITS-1:0]           rsp_data,
  output logic                           rom_enable,
  output logic [ADDR_BITS-1:0]           rom_addr,
  input  logic [DATA_BITS-1:0]           rom_data
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 r_pend;
  logic [NUM_REQ-1:0]   r_owner;
  logic [PTR_W-1:0]     r_rr_ptr;

  logic                 w_found;
  logic [PTR_W-1:0]     w_winner;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_retire;
  logic                 w_can_issue;
  logic                 w_issue;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ADDR_BITS-1:0] w_addr [NUM_REQ];

  // Unpack the flat lane address bus
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_addr[i] = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Scan from the lane after the last winner; the first valid lane wins
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign rsp_valid   = r_pend ? r_owner : '0;
  assign w_retire    = |(rsp_valid & rsp_ready);
  assign w_can_issue = !r_pend || w_retire;
  // Reset blocks issue immediately, not just at the next edge
  assign w_issue     = w_found && w_can_issue && !reset;
  assign w_grant     = NUM_REQ'(1) << w_winner;

  assign req_ready  = w_issue ? w_grant : '0;
  assign rom_enable = w_issue;
  assign rom_addr   = w_issue ? w_addr[w_winner] : '0;
  assign rsp_data   = rom_data;

  // Pending-response ownership and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= PTR_W'(NUM_REQ - 1);
    end else if (w_issue) begin
      r_pend   <= 1'b1;
      r_owner  <= w_grant;
      r_rr_ptr <= w_winner;
    end else if (w_retire) begin
      r_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_requantize_exp_arbiter.sv
// Directed bench for requantize_exp_arbiter with a behavioural exponent ROM
// (data = {23'h0, addr} + 32'h1000_0000, one-cycle latency, holds when disabled).
module tb_requantize_exp_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned ADDR_BITS = 9;
  localparam int unsigned DATA_BITS = 32;

  logic                         clk;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [DATA_BITS-1:0]         rsp_data;
  logic                         rom_enable;
  logic [ADDR_BITS-1:0]         rom_addr;
  logic [DATA_BITS-1:0]         rom_data;

  int n_assert;
  int n_fail;

  requantize_exp_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model
  always @(posedge clk) begin
    if (rom_enable) rom_data <= {23'h0, rom_addr} + 32'h1000_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_req(input string tag, input logic [1:0] rdy, input logic en,
                         input logic [8:0] addr);
    chk({tag, "_req_ready"},  32'(req_ready),  32'(rdy));
    chk({tag, "_rom_enable"}, 32'(rom_enable), 32'(en));
    chk({tag, "_rom_addr"},   32'(rom_addr),   32'(addr));
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] vld, input logic [31:0] data);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(vld));
    chk({tag, "_rsp_data"},  rsp_data,       data);
  endtask

  logic [1:0]  exp_grant [4];
  logic [8:0]  exp_addr  [4];
  logic [1:0]  exp_rv    [4];
  logic [31:0] exp_rd    [4];

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rom_data  = '0;
    reset     = 1'b1;
    req_valid = 2'b11;
    req_addr  = {9'h002, 9'h001};
    rsp_ready = 2'b11;
    #1;
    chk_req("reset_hold", 2'b00, 1'b0, 9'h000);
    chk("reset_hold_rsp_valid", 32'(rsp_valid), 32'h0);
    cyc();
    cyc();
    req_valid = 2'b00;
    reset     = 1'b0;
    #1;
    chk_req("idle", 2'b00, 1'b0, 9'h000);

    // Single lookup on lane 1
    req_valid = 2'b10;
    req_addr  = {9'h010, 9'h000};
    #1;
    chk_req("single", 2'b10, 1'b1, 9'h010);
    cyc();
    req_valid = 2'b00;
    #1;
    chk_rsp("single", 2'b10, 32'h1000_0010);
    chk_req("single_after", 2'b00, 1'b0, 9'h000);
    cyc();
    chk("single_retired", 32'(rsp_valid), 32'h0);

    // Contention: both lanes valid, grants alternate starting at lane 0
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr  = '{9'h020, 9'h021, 9'h020, 9'h021};
    exp_rv    = '{2'b00, 2'b01, 2'b10, 2'b01};
    exp_rd    = '{32'h0, 32'h1000_0020, 32'h1000_0021, 32'h1000_0020};
    req_valid = 2'b11;
    req_addr  = {9'h021, 9'h020};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_req($sformatf("contend%0d", i), exp_grant[i], 1'b1, exp_addr[i]);
      chk($sformatf("contend%0d_rsp_valid", i), 32'(rsp_valid), 32'(exp_rv[i]));
      if (i > 0) chk($sformatf("contend%0d_rsp_data", i), rsp_data, exp_rd[i]);
      cyc();
    end

    // Backpressure: lane 0 response stalled while lane 1 waits
    req_valid = 2'b01;
    req_addr  = {9'h000, 9'h033};
    #1;
    chk_rsp("bp_prev", 2'b10, 32'h1000_0021);
    chk_req("bp_issue", 2'b01, 1'b1, 9'h033);
    cyc();
    rsp_ready = 2'b10;
    req_valid = 2'b10;
    req_addr  = {9'h044, 9'h000};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_req($sformatf("bp_stall%0d", i), 2'b00, 1'b0, 9'h000);
      chk_rsp($sformatf("bp_stall%0d", i), 2'b01, 32'h1000_0033);
      cyc();
    end
    rsp_ready = 2'b11;
    #1;
    chk_req("bp_release", 2'b10, 1'b1, 9'h044);
    cyc();
    req_valid = 2'b00;
    #1;
    chk_rsp("bp_rsp", 2'b10, 32'h1000_0044);

    // Address boundaries
    req_valid = 2'b01;
    req_addr  = {9'h000, 9'h1FF};
    #1;
    chk_req("addr_max", 2'b01, 1'b1, 9'h1FF);
    cyc();
    req_valid = 2'b10;
    req_addr  = {9'h000, 9'h000};
    #1;
    chk_rsp("addr_max", 2'b01, 32'h1000_01FF);
    chk_req("addr_zero", 2'b10, 1'b1, 9'h000);
    cyc();
    req_valid = 2'b00;
    #1;
    chk_rsp("addr_zero", 2'b10, 32'h1000_0000);
    cyc();

    // Reset the cycle after a grant drops the response
    req_valid = 2'b10;
    req_addr  = {9'h055, 9'h000};
    #1;
    chk_req("rst_grant", 2'b10, 1'b1, 9'h055);
    cyc();
    chk("rst_pending", 32'(rsp_valid), 32'h2);
    req_valid = 2'b11;
    reset     = 1'b1;
    #1;
    chk_req("rst_mid", 2'b00, 1'b0, 9'h000);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    cyc();
    chk_req("rst_held", 2'b00, 1'b0, 9'h000);
    chk("rst_held_rsp_valid", 32'(rsp_valid), 32'h0);
    reset = 1'b0;
    #1;
    chk_req("post_rst", 2'b01, 1'b1, 9'h000);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("post_rst_rsp", 32'(rsp_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
